// File: rtl/key_event_conditioner.sv
// key_event_conditioner
// Synchronises and debounces the DE10-Nano push-buttons and slide switches,
// produces clean levels plus one-cycle key press pulses, and logs every
// debounced change into an event FIFO that the HPS drains over Avalon-MM.
// Optional build macro: KEY_AUTOREPEAT_EN adds per-key auto-repeat pulses on
// key_press while a key is held (REPEAT_DELAY, then every REPEAT_PERIOD).
module key_event_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int FIFO_DEPTH      = 8,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  key_n,
    input  logic [3:0]  switch_raw,
    output logic [1:0]  key_level,
    output logic [1:0]  key_press,
    output logic [3:0]  switch_clean,
    input  logic [1:0]  address,
    input  logic        read,
    output logic [31:0] readdata,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic        irq
);

    localparam int N_IN  = 6;
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] FIFO_FULLC = CNT_W'(FIFO_DEPTH);

    // Inputs viewed as one vector: keys (made active-high) low, switches high.
    logic [N_IN-1:0] raw_vec;
    assign raw_vec = {switch_raw, ~key_n};

    logic [N_IN-1:0] sync1_reg;
    logic [N_IN-1:0] sync2_reg;

    // Two-flop synchroniser for every asynchronous input.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= raw_vec;
            sync2_reg <= sync1_reg;
        end
    end

    logic [N_IN-1:0] stable_reg;
    logic [N_IN-1:0] stable_next;
    logic [N_IN-1:0] change_mask;

    genvar gi;
    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_debounce
            logic [DB_W-1:0] db_cnt_reg;
            logic            mismatch;

            assign mismatch        = sync2_reg[gi] != stable_reg[gi];
            assign stable_next[gi] = (mismatch && db_cnt_reg == DB_LAST) ? sync2_reg[gi]
                                                                         : stable_reg[gi];

            // Count consecutive mismatch cycles; any agreement restarts the count.
            always_ff @(posedge clk) begin
                if (reset) begin
                    db_cnt_reg <= '0;
                end else if (!mismatch || db_cnt_reg == DB_LAST) begin
                    db_cnt_reg <= '0;
                end else begin
                    db_cnt_reg <= db_cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

    assign change_mask = stable_next ^ stable_reg;

    // Accepted (debounced) input levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_reg <= '0;
        end else begin
            stable_reg <= stable_next;
        end
    end

    assign key_level    = stable_reg[1:0];
    assign switch_clean = stable_reg[5:2];

    logic [1:0] repeat_fire;

`ifdef KEY_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    generate
        for (gi = 0; gi < 2; gi++) begin : g_repeat
            logic [RPT_W-1:0] rpt_cnt_reg;
            logic             rpt_phase_reg;
            logic [RPT_W-1:0] rpt_target;

            // First repeat waits REPEAT_DELAY after the press, later ones REPEAT_PERIOD.
            assign rpt_target      = rpt_phase_reg ? RPT_W'(REPEAT_PERIOD - 1)
                                                   : RPT_W'(REPEAT_DELAY - 1);
            assign repeat_fire[gi] = stable_reg[gi] && (rpt_cnt_reg == rpt_target);

            // Hold-time counter; released keys restart from the first-delay phase.
            always_ff @(posedge clk) begin
                if (reset || !stable_reg[gi]) begin
                    rpt_cnt_reg   <= '0;
                    rpt_phase_reg <= 1'b0;
                end else if (repeat_fire[gi]) begin
                    rpt_cnt_reg   <= '0;
                    rpt_phase_reg <= 1'b1;
                end else begin
                    rpt_cnt_reg   <= rpt_cnt_reg + 1'b1;
                end
            end
        end
    endgenerate
`else
    logic [1:0] unused_repeat_cfg;
    assign unused_repeat_cfg = {REPEAT_DELAY[0], REPEAT_PERIOD[0]};
    assign repeat_fire       = '0;
`endif

    logic [1:0] key_prev_reg;
    logic [1:0] key_press_reg;

    // One-cycle pulse the cycle after a key level rises (plus any repeats).
    always_ff @(posedge clk) begin
        if (reset) begin
            key_prev_reg  <= '0;
            key_press_reg <= '0;
        end else begin
            key_prev_reg  <= stable_reg[1:0];
            key_press_reg <= (stable_reg[1:0] & ~key_prev_reg) | repeat_fire;
        end
    end

    assign key_press = key_press_reg;

    // Event FIFO: pointers carry one extra wrap bit so full and empty differ.
    logic [31:0]      fifo_mem [FIFO_DEPTH];
    logic [CNT_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] fifo_count;
    logic [7:0]       seq_reg;
    logic             overflow_reg;
    logic             irq_en_reg;
    logic             irq_reg;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic             push_ok;
    logic             drop;
    logic [31:0]      event_word;
    logic [31:0]      status_word;

    assign fifo_count = wr_ptr_reg - rd_ptr_reg;
    assign fifo_empty = fifo_count == '0;
    assign fifo_full  = fifo_count == FIFO_FULLC;
    assign push       = |change_mask;
    assign pop        = read && (address == 2'd0) && !fifo_empty;
    assign push_ok    = push && (!fifo_full || pop);
    assign drop       = push && fifo_full && !pop;
    assign event_word = {1'b1, 7'd0, seq_reg, 4'd0, change_mask, stable_next};
    assign status_word = {21'd0, overflow_reg, fifo_full, fifo_empty, 1'b0, 7'(fifo_count)};

    // Event storage; a simultaneous pop of the same slot reads the old word.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= event_word;
        end
    end

    // FIFO pointers, sequence number, overflow flag, irq enable and irq.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            seq_reg      <= '0;
            overflow_reg <= 1'b0;
            irq_en_reg   <= 1'b0;
            irq_reg      <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push) begin
                seq_reg <= seq_reg + 1'b1;
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (write && address == 2'd1 && writedata[10]) begin
                overflow_reg <= 1'b0;
            end
            if (write && address == 2'd2) begin
                irq_en_reg <= writedata[0];
            end
            irq_reg <= irq_en_reg && !fifo_empty;
        end
    end

    // Registered read data, held until the next read.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else if (read) begin
            case (address)
                2'd0:    readdata <= fifo_empty ? 32'd0 : fifo_mem[rd_ptr_reg[PTR_W-1:0]];
                2'd1:    readdata <= status_word;
                2'd2:    readdata <= {31'd0, irq_en_reg};
                default: readdata <= {26'd0, stable_reg};
            endcase
        end
    end

    assign irq = irq_reg;

    logic unused_wdata;
    assign unused_wdata = ^{writedata[31:11], writedata[9:1]};

endmodule

// File: tb/tb_key_event_conditioner.sv
// Testbench for key_event_conditioner: register table, hand-written corner
// sequences and a randomized run, all checked every cycle against a
// behavioural model (sliding debounce window, queue-based FIFO).
module tb_key_event_conditioner;

    localparam int DEB   = 4;
    localparam int DEPTH = 4;
    localparam int RDLY  = 10;
    localparam int RPER  = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  key_n = 2'b11;
    logic [3:0]  switch_raw = 4'd0;
    logic [1:0]  address = 2'd0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'd0;
    logic [1:0]  key_level;
    logic [1:0]  key_press;
    logic [3:0]  switch_clean;
    logic [31:0] readdata;
    logic        irq;

    always #5 clk = ~clk;

    key_event_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .FIFO_DEPTH     (DEPTH),
        .REPEAT_DELAY   (RDLY),
        .REPEAT_PERIOD  (RPER)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_n       (key_n),
        .switch_raw  (switch_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .switch_clean(switch_clean),
        .address     (address),
        .read        (read),
        .readdata    (readdata),
        .write       (write),
        .writedata   (writedata),
        .irq         (irq)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [5:0]  m_s1, m_s2, m_stable, m_stable_prev;
    logic [5:0]  m_hist[$];
    logic [31:0] m_q[$];
    logic [7:0]  m_seq;
    logic        m_ovf, m_irq_en, m_irq;
    logic [31:0] m_rd;
    logic [1:0]  m_press;
    int          m_age[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs the DUT just sampled.
    task automatic model_edge();
        logic [5:0]  old_st, new_st, mask;
        logic [31:0] ev;
        bit          drop, all_diff;
        int          qsz;
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_stable_prev = '0;
            m_hist.delete(); m_q.delete();
            m_seq = '0; m_ovf = 0; m_irq_en = 0; m_irq = 0; m_rd = '0; m_press = '0;
            m_age[0] = 0; m_age[1] = 0;
            return;
        end
        old_st  = m_stable;
        qsz     = m_q.size();
        m_irq   = m_irq_en && (qsz != 0);
        m_press = m_stable[1:0] & ~m_stable_prev[1:0];
`ifdef KEY_AUTOREPEAT_EN
        for (int k = 0; k < 2; k++) begin
            if (old_st[k]) m_age[k]++; else m_age[k] = 0;
            if (m_age[k] == RDLY || (m_age[k] > RDLY && (m_age[k] - RDLY) % RPER == 0))
                m_press[k] = 1'b1;
        end
`endif
        // A bit flips once the last DEB synchronised samples all disagree with it.
        m_hist.push_front(m_s2);
        if (m_hist.size() > DEB) void'(m_hist.pop_back());
        new_st = old_st;
        if (m_hist.size() == DEB) begin
            for (int i = 0; i < 6; i++) begin
                all_diff = 1;
                foreach (m_hist[j]) if (m_hist[j][i] == old_st[i]) all_diff = 0;
                if (all_diff) new_st[i] = ~old_st[i];
            end
        end
        mask = new_st ^ old_st;
        if (read) begin
            case (address)
                2'd0: begin
                    if (qsz != 0) m_rd = m_q.pop_front();
                    else m_rd = '0;
                end
                2'd1: m_rd = {21'd0, m_ovf, qsz == DEPTH, qsz == 0, 1'b0, 7'(qsz)};
                2'd2: m_rd = {31'd0, m_irq_en};
                default: m_rd = {26'd0, old_st};
            endcase
        end
        drop = 0;
        if (mask != 0) begin
            ev = {1'b1, 7'd0, m_seq, 4'd0, mask, new_st};
            if (m_q.size() < DEPTH) m_q.push_back(ev);
            else drop = 1;
            m_seq++;
        end
        if (drop) m_ovf = 1;
        else if (write && address == 2'd1 && writedata[10]) m_ovf = 0;
        if (write && address == 2'd2) m_irq_en = writedata[0];
        m_stable_prev = old_st;
        m_stable      = new_st;
        m_s2 = m_s1;
        m_s1 = {switch_raw, ~key_n};
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("key_level", key_level, m_stable[1:0]);
        chk("switch_clean", switch_clean, m_stable[5:2]);
        chk("key_press", key_press, m_press);
        chk("irq", irq, m_irq);
        chk("readdata", readdata, m_rd);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a);
        address = a; read = 1'b1;
        step();
        read = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; write = 1'b1; writedata = d;
        step();
        write = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  addr;
        logic        rd_en;
        logic        wr_en;
        logic [31:0] wdata;
        logic [31:0] exp;
    } reg_vec_t;

    reg_vec_t tbl[11];
    logic     rep_on;

    initial begin
        logic [31:0] exp32;
        tbl[0]  = '{2'd1, 1'b1, 1'b0, 32'h0,        32'h100};
        tbl[1]  = '{2'd2, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h0};
        tbl[2]  = '{2'd2, 1'b1, 1'b0, 32'h0,        32'h1};
        tbl[3]  = '{2'd3, 1'b1, 1'b0, 32'h0,        32'h0};
        tbl[4]  = '{2'd0, 1'b1, 1'b0, 32'h0,        32'h0};
        tbl[5]  = '{2'd0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h0};
        tbl[6]  = '{2'd1, 1'b1, 1'b0, 32'h0,        32'h100};
        tbl[7]  = '{2'd2, 1'b0, 1'b1, 32'h2,        32'h0};
        tbl[8]  = '{2'd2, 1'b1, 1'b0, 32'h0,        32'h0};
        tbl[9]  = '{2'd3, 1'b0, 1'b1, 32'h3F,       32'h0};
        tbl[10] = '{2'd3, 1'b1, 1'b0, 32'h0,        32'h0};
`ifdef KEY_AUTOREPEAT_EN
        rep_on = 1'b1;
`else
        rep_on = 1'b0;
`endif

        // Reset and idle
        do_reset();
        repeat (20) step();
        chk("idle_key_level", key_level, 2'b00);
        chk("idle_switch_clean", switch_clean, 4'h0);
        chk("idle_key_press", key_press, 2'b00);
        chk("idle_irq", irq, 1'b0);
        chk("idle_readdata", readdata, 32'h0);
        rd(2'd1);
        chk("idle_status", readdata, 32'h100);

        // Register table
        for (int i = 0; i < 11; i++) begin
            address = tbl[i].addr; read = tbl[i].rd_en;
            write = tbl[i].wr_en; writedata = tbl[i].wdata;
            step();
            read = 1'b0; write = 1'b0;
            if (tbl[i].rd_en) chk($sformatf("table_%0d", i), readdata, tbl[i].exp);
        end

        // Key 0 press latency and pulse
        do_reset();
        key_n = 2'b10;
        for (int j = 1; j <= 8; j++) begin
            step();
            if (j == 5) chk("press_lvl_t5", key_level, 2'b00);
            if (j == 6) begin
                chk("press_lvl_t6", key_level, 2'b01);
                chk("press_pulse_t6", key_press, 2'b00);
            end
            if (j == 7) chk("press_pulse_t7", key_press, 2'b01);
            if (j == 8) chk("press_pulse_t8", key_press, 2'b00);
        end
        rd(2'd0);
        chk("press_event", readdata, 32'h80000041);
        rd(2'd1);
        chk("press_status_after_pop", readdata, 32'h100);

        // Short glitch on key 1
        key_n = 2'b00;
        repeat (3) step();
        key_n = 2'b10;
        for (int j = 0; j < 12; j++) begin
            step();
            chk("glitch_level", key_level, 2'b01);
            chk("glitch_press", key_press, 2'b00);
        end
        rd(2'd1);
        chk("glitch_status", readdata, 32'h100);

        // Overflow, irq and draining
        key_n = 2'b11;
        do_reset();
        wr(2'd2, 32'h1);
        for (int t = 0; t < 6; t++) begin
            switch_raw[0] = ~switch_raw[0];
            repeat (8) step();
        end
        rd(2'd1);
        chk("ovf_status", readdata, 32'h604);
        chk("ovf_irq", irq, 1'b1);
        for (int p = 0; p < 4; p++) begin
            rd(2'd0);
            exp32 = 32'(p);
            chk("drain_seq", 32'(readdata[23:16]), exp32);
            chk("drain_valid", readdata[31], 1'b1);
            chk("drain_irq", irq, 1'b1);
        end
        rd(2'd0);
        chk("drain_empty_read", readdata, 32'h0);
        chk("drain_irq_fall", irq, 1'b0);
        wr(2'd1, 32'h400);
        rd(2'd1);
        chk("ovf_cleared_status", readdata, 32'h100);

        // Push landing on a pop while full
        do_reset();
        for (int t = 0; t < 4; t++) begin
            switch_raw[0] = ~switch_raw[0];
            repeat (8) step();
        end
        rd(2'd1);
        chk("full_status", readdata, 32'h204);
        switch_raw[0] = ~switch_raw[0];
        repeat (5) step();
        address = 2'd0; read = 1'b1;
        step();
        read = 1'b0;
        chk("full_pop_head", readdata, 32'h80000104);
        rd(2'd1);
        chk("full_pushpop_status", readdata, 32'h204);
        repeat (4) rd(2'd0);
        chk("full_last_seq", 32'(readdata[23:16]), 32'd4);

        // Held key: auto-repeat (if built) and a single FIFO event
        do_reset();
        key_n = 2'b10;
        repeat (6) step();
        chk("hold_accept", key_level, 2'b01);
        for (int j = 1; j <= 31; j++) begin
            step();
            chk($sformatf("hold_press_%0d", j), key_press[0],
                (j == 1) || (rep_on && j >= RDLY && (j - RDLY) % RPER == 0));
        end
        rd(2'd1);
        chk("hold_status", readdata, 32'h001);
        key_n = 2'b11;
        do_reset();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(5) == 0) begin
                int b;
                b = $urandom_range(5);
                if (b < 2) key_n[b] = ~key_n[b];
                else switch_raw[b-2] = ~switch_raw[b-2];
            end
            address   = 2'($urandom_range(3));
            read      = ($urandom_range(3) == 0);
            write     = ($urandom_range(9) == 0);
            writedata = $urandom;
            reset     = (n == 1500);
            step();
        end
        reset = 1'b0; read = 1'b0; write = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
